// File: rtl/vx_csr_access_arb_pkg.sv
// Shared types for the CSR access arbiter: op encodings, FSM states and
// the helper that decides whether an op writes the CSR back.
package vx_csr_access_arb_pkg;

    localparam int CSR_OP_W = 2;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } arb_state_e;

    // Set/clear with a zero operand (x0 or zero immediate) must not touch the CSR.
    function automatic logic csrOpWrites(input csr_op_e op, input logic skip);
        case (op)
            CSR_OP_RW:            return 1'b1;
            CSR_OP_RS, CSR_OP_RC: return !skip;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/vx_csr_access_arb_rr.sv
// Round-robin selector: the search starts at the pointer, and the pointer
// moves past the winner only when the grant is actually taken.
module vx_csr_access_arb_rr #(
    parameter int NUM_REQS = 2,
    parameter int IDX_W    = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] i_valid,
    input  logic                i_enable,
    output logic [NUM_REQS-1:0] o_grant,
    output logic [IDX_W-1:0]    o_index,
    output logic                o_any
);

    logic [IDX_W-1:0] r_ptr;

    always_comb begin
        int cand;
        cand    = 0;
        o_grant = '0;
        o_index = '0;
        o_any   = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            cand = int'(r_ptr) + i;
            if (cand >= NUM_REQS) begin
                cand = cand - NUM_REQS;
            end
            if (!o_any && i_valid[cand]) begin
                o_any         = 1'b1;
                o_grant[cand] = 1'b1;
                o_index       = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_enable && o_any) begin
            r_ptr <= (o_index == IDX_W'(NUM_REQS - 1)) ? '0 : o_index + 1'b1;
        end
    end

endmodule

// File: rtl/vx_csr_access_arb.sv
// Serialises CSR read-modify-write requests from several requesters onto one
// CSR port: grant, read, write, respond, with one transaction in flight.
module vx_csr_access_arb
    import vx_csr_access_arb_pkg::*;
#(
    parameter int NUM_REQS   = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 12,
    parameter int NW_WIDTH   = 2,
    parameter int UUID_WIDTH = 44,
    localparam int IDX_W     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQS-1:0]              req_valid,
    output logic [NUM_REQS-1:0]              req_ready,
    input  logic [NUM_REQS*CSR_OP_W-1:0]     req_op,
    input  logic [NUM_REQS*ADDR_BITS-1:0]    req_addr,
    input  logic [NUM_REQS*NW_WIDTH-1:0]     req_wid,
    input  logic [NUM_REQS*UUID_WIDTH-1:0]   req_uuid,
    input  logic [NUM_REQS*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQS-1:0]              req_wr_skip,
    output logic                             csr_read_enable,
    output logic [ADDR_BITS-1:0]             csr_read_addr,
    output logic [NW_WIDTH-1:0]              csr_read_wid,
    output logic [UUID_WIDTH-1:0]            csr_read_uuid,
    input  logic [DATA_WIDTH-1:0]            csr_read_data_ro,
    input  logic [DATA_WIDTH-1:0]            csr_read_data_rw,
    output logic                             csr_write_enable,
    output logic [ADDR_BITS-1:0]             csr_write_addr,
    output logic [NW_WIDTH-1:0]              csr_write_wid,
    output logic [UUID_WIDTH-1:0]            csr_write_uuid,
    output logic [DATA_WIDTH-1:0]            csr_write_data,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [IDX_W-1:0]                 rsp_idx,
    output logic [DATA_WIDTH-1:0]            rsp_data
);

    arb_state_e r_state;
    arb_state_e w_stateNext;

    logic [NUM_REQS-1:0]   w_grant;
    logic [IDX_W-1:0]      w_grantIdx;
    logic                  w_grantAny;
    logic                  w_reqFire;

    csr_op_e               r_op;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [NW_WIDTH-1:0]   r_wid;
    logic [UUID_WIDTH-1:0] r_uuid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_skip;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_old;

    logic [DATA_WIDTH-1:0] w_newValue;
    logic                  w_doWrite;

    assign w_reqFire = (r_state == ST_IDLE) && w_grantAny && !reset;

    vx_csr_access_arb_rr #(
        .NUM_REQS (NUM_REQS),
        .IDX_W    (IDX_W)
    ) u_rr (
        .clk      (clk),
        .reset    (reset),
        .i_valid  (req_valid),
        .i_enable (w_reqFire),
        .o_grant  (w_grant),
        .o_index  (w_grantIdx),
        .o_any    (w_grantAny)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Enables are forced low during reset so an aborted transaction never
    // shows a write pulse or response in the cycle reset is applied.
    always_comb begin
        w_stateNext      = r_state;
        req_ready        = '0;
        csr_read_enable  = 1'b0;
        csr_write_enable = 1'b0;
        rsp_valid        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = w_grant;
                if (w_grantAny) begin
                    w_stateNext = ST_READ;
                end
            end
            ST_READ: begin
                csr_read_enable = 1'b1;
                w_stateNext     = ST_WRITE;
            end
            ST_WRITE: begin
                csr_write_enable = w_doWrite;
                w_stateNext      = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
        if (reset) begin
            req_ready        = '0;
            csr_read_enable  = 1'b0;
            csr_write_enable = 1'b0;
            rsp_valid        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op   <= CSR_OP_NONE;
            r_addr <= '0;
            r_wid  <= '0;
            r_uuid <= '0;
            r_data <= '0;
            r_skip <= 1'b0;
            r_idx  <= '0;
            r_old  <= '0;
        end else begin
            if (w_reqFire) begin
                r_op   <= csr_op_e'(req_op[w_grantIdx*CSR_OP_W +: CSR_OP_W]);
                r_addr <= req_addr[w_grantIdx*ADDR_BITS +: ADDR_BITS];
                r_wid  <= req_wid[w_grantIdx*NW_WIDTH +: NW_WIDTH];
                r_uuid <= req_uuid[w_grantIdx*UUID_WIDTH +: UUID_WIDTH];
                r_data <= req_data[w_grantIdx*DATA_WIDTH +: DATA_WIDTH];
                r_skip <= req_wr_skip[w_grantIdx];
                r_idx  <= w_grantIdx;
            end
            if (r_state == ST_READ) begin
                r_old <= csr_read_data_ro | csr_read_data_rw;
            end
        end
    end

    // Reserved op 00 behaves as a pure read: old value returned, nothing written.
    always_comb begin
        w_newValue = r_old;
        w_doWrite  = csrOpWrites(r_op, r_skip);
        case (r_op)
            CSR_OP_RW: w_newValue = r_data;
            CSR_OP_RS: w_newValue = r_old | r_data;
            CSR_OP_RC: w_newValue = r_old & ~r_data;
            default:   w_newValue = r_old;
        endcase
    end

    assign csr_read_addr  = r_addr;
    assign csr_read_wid   = r_wid;
    assign csr_read_uuid  = r_uuid;
    assign csr_write_addr = r_addr;
    assign csr_write_wid  = r_wid;
    assign csr_write_uuid = r_uuid;
    assign csr_write_data = w_newValue;
    assign rsp_idx        = r_idx;
    assign rsp_data       = r_old;

endmodule

// File: tb/tb_vx_csr_access_arb.sv
// Scoreboard bench for vx_csr_access_arb: a transaction-level model predicts
// grants, CSR read/write pulses and responses; a monitor compares each cycle.
module tb_vx_csr_access_arb;

    localparam int NR = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [3:0]    req_op;
    logic [23:0]   req_addr;
    logic [3:0]    req_wid;
    logic [87:0]   req_uuid;
    logic [63:0]   req_data;
    logic [1:0]    req_wr_skip;
    logic          csr_read_enable;
    logic [11:0]   csr_read_addr;
    logic [1:0]    csr_read_wid;
    logic [43:0]   csr_read_uuid;
    logic [31:0]   csr_read_data_ro;
    logic [31:0]   csr_read_data_rw;
    logic          csr_write_enable;
    logic [11:0]   csr_write_addr;
    logic [1:0]    csr_write_wid;
    logic [43:0]   csr_write_uuid;
    logic [31:0]   csr_write_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [0:0]    rsp_idx;
    logic [31:0]   rsp_data;

    vx_csr_access_arb dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_addr         (req_addr),
        .req_wid          (req_wid),
        .req_uuid         (req_uuid),
        .req_data         (req_data),
        .req_wr_skip      (req_wr_skip),
        .csr_read_enable  (csr_read_enable),
        .csr_read_addr    (csr_read_addr),
        .csr_read_wid     (csr_read_wid),
        .csr_read_uuid    (csr_read_uuid),
        .csr_read_data_ro (csr_read_data_ro),
        .csr_read_data_rw (csr_read_data_rw),
        .csr_write_enable (csr_write_enable),
        .csr_write_addr   (csr_write_addr),
        .csr_write_wid    (csr_write_wid),
        .csr_write_uuid   (csr_write_uuid),
        .csr_write_data   (csr_write_data),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_idx          (rsp_idx),
        .rsp_data         (rsp_data)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // CSR file seen by the DUT: four CSRs at 0x340..0x343, split across the
    // ro/rw read buses so the OR of both is needed to recover the value.
    function automatic logic [31:0] initVal(input int slot);
        case (slot)
            0:       return 32'h0000_1234;
            1:       return 32'h0000_000F;
            2:       return 32'h0000_0055;
            default: return 32'h0000_A5A5;
        endcase
    endfunction

    logic [31:0] envMem [4];

    always @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < 4; s++) envMem[s] <= initVal(s);
        end else if (csr_write_enable) begin
            envMem[csr_write_addr[1:0]] <= csr_write_data;
        end
    end

    assign csr_read_data_ro = envMem[csr_read_addr[1:0]] & 32'hFFFF_0000;
    assign csr_read_data_rw = envMem[csr_read_addr[1:0]] & 32'h0000_FFFF;

    typedef struct { int cyc; logic [11:0] addr; logic [1:0] wid; logic [43:0] uuid; } rdExp_t;
    typedef struct { int cyc; logic [11:0] addr; logic [31:0] data; } wrExp_t;
    typedef struct { int cyc; int idx; logic [31:0] data; } rspExp_t;

    rdExp_t  rdQ[$];
    wrExp_t  wrQ[$];
    rspExp_t rspQ[$];
    int      grantLog[$];

    logic [31:0] modelMem [4];
    int          mPtr = 0;
    bit          busy = 1'b0;
    int          writeCount = 0;
    int          rspCount = 0;
    logic [31:0] lastRspData = '0;
    int          lastRspIdx = -1;

    // Monitor: transaction model. A grant at cycle T means read at T+1,
    // write at T+2 and a response available from T+3 until accepted.
    always @(negedge clk) begin
        logic [1:0]  expReady;
        int          win;
        int          c;
        logic [1:0]  op;
        logic [11:0] a;
        logic [31:0] d;
        logic [31:0] oldV;
        logic [31:0] newV;
        bit          wr;
        bit          expRd;
        bit          expWr;
        bit          expRsp;

        if (csr_write_enable) writeCount++;
        if (reset) begin
            checkOutput("resetReady", {62'd0, req_ready}, 64'd0);
            checkOutput("resetReadEn", {63'd0, csr_read_enable}, 64'd0);
            checkOutput("resetWriteEn", {63'd0, csr_write_enable}, 64'd0);
            checkOutput("resetRspValid", {63'd0, rsp_valid}, 64'd0);
            rdQ.delete();
            wrQ.delete();
            rspQ.delete();
            busy = 1'b0;
            mPtr = 0;
            for (int s = 0; s < 4; s++) modelMem[s] = initVal(s);
        end else begin
            expReady = '0;
            win = -1;
            if (!busy) begin
                for (int k = 0; k < NR; k++) begin
                    c = (mPtr + k) % NR;
                    if (win < 0 && req_valid[c]) win = c;
                end
            end
            if (win >= 0) expReady[win] = 1'b1;
            checkOutput("grant", {62'd0, req_ready}, {62'd0, expReady});

            if (win >= 0) begin
                op   = req_op[win*2 +: 2];
                a    = req_addr[win*12 +: 12];
                d    = req_data[win*32 +: 32];
                oldV = modelMem[a[1:0]];
                newV = oldV;
                wr   = 1'b0;
                case (op)
                    2'b01: begin newV = d;           wr = 1'b1; end
                    2'b10: begin newV = oldV | d;    wr = !req_wr_skip[win]; end
                    2'b11: begin newV = oldV & ~d;   wr = !req_wr_skip[win]; end
                    default: wr = 1'b0;
                endcase
                rdQ.push_back('{cyc + 1, a, req_wid[win*2 +: 2], req_uuid[win*44 +: 44]});
                if (wr) wrQ.push_back('{cyc + 2, a, newV});
                rspQ.push_back('{cyc + 3, win, oldV});
                busy = 1'b1;
                mPtr = (win + 1) % NR;
                grantLog.push_back(win);
            end

            expRd = (rdQ.size() > 0) && (rdQ[0].cyc == cyc);
            checkOutput("readEnable", {63'd0, csr_read_enable}, {63'd0, expRd});
            if (expRd) begin
                if (csr_read_enable) begin
                    checkOutput("readAddr", {52'd0, csr_read_addr}, {52'd0, rdQ[0].addr});
                    checkOutput("readWid", {62'd0, csr_read_wid}, {62'd0, rdQ[0].wid});
                    checkOutput("readUuid", {20'd0, csr_read_uuid}, {20'd0, rdQ[0].uuid});
                end
                void'(rdQ.pop_front());
            end

            expWr = (wrQ.size() > 0) && (wrQ[0].cyc == cyc);
            checkOutput("writeEnable", {63'd0, csr_write_enable}, {63'd0, expWr});
            if (expWr) begin
                if (csr_write_enable) begin
                    checkOutput("writeAddr", {52'd0, csr_write_addr}, {52'd0, wrQ[0].addr});
                    checkOutput("writeData", {32'd0, csr_write_data}, {32'd0, wrQ[0].data});
                end
                modelMem[wrQ[0].addr[1:0]] = wrQ[0].data;
                void'(wrQ.pop_front());
            end

            expRsp = (rspQ.size() > 0) && (rspQ[0].cyc <= cyc);
            checkOutput("rspValid", {63'd0, rsp_valid}, {63'd0, expRsp});
            if (expRsp && rsp_valid) begin
                checkOutput("rspIdx", {63'd0, rsp_idx}, 64'(rspQ[0].idx));
                checkOutput("rspData", {32'd0, rsp_data}, {32'd0, rspQ[0].data});
                if (rsp_ready) begin
                    lastRspData = rspQ[0].data;
                    lastRspIdx  = rspQ[0].idx;
                    rspCount++;
                    busy = 1'b0;
                    void'(rspQ.pop_front());
                end
            end
        end
    end

    task automatic applyStimulus(input int r, input logic [1:0] op, input logic [11:0] addr,
                                 input logic [31:0] data, input logic skip);
        logic [63:0] u;
        u = {$urandom, $urandom};
        req_op[r*2 +: 2]     = op;
        req_addr[r*12 +: 12] = addr;
        req_wid[r*2 +: 2]    = 2'($urandom_range(0, 3));
        req_uuid[r*44 +: 44] = u[43:0];
        req_data[r*32 +: 32] = data;
        req_wr_skip[r]       = skip;
        req_valid[r]         = 1'b1;
    endtask

    task automatic waitAccept(input int r);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (req_valid[r] && req_ready[r] && !reset) got = 1'b1;
        end
        @(posedge clk);
        #1 req_valid[r] = 1'b0;
        checkOutput("acceptInTime", {63'd0, got}, 64'd1);
    endtask

    task automatic waitIdle();
        for (int n = 0; n < 100 && busy; n++) @(posedge clk);
        checkOutput("idleInTime", {63'd0, busy}, 64'd0);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int          wcBefore;
        int          rcBefore;
        logic [1:0]  acc;
        logic [63:0] u;

        reset       = 1'b1;
        req_valid   = '0;
        req_op      = '0;
        req_addr    = '0;
        req_wid     = '0;
        req_uuid    = '0;
        req_data    = '0;
        req_wr_skip = '0;
        rsp_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Read-write: old 0x1234 returned, 0xDEAD written.
        applyStimulus(0, 2'b01, 12'h340, 32'h0000_DEAD, 1'b0);
        waitAccept(0);
        waitIdle();
        checkOutput("rwRspData", {32'd0, lastRspData}, 64'h1234);
        checkOutput("rwRspIdx", 64'(lastRspIdx), 64'd0);
        checkOutput("rwCsrValue", {32'd0, envMem[0]}, 64'hDEAD);

        // Set then clear on CSR 0x341.
        applyStimulus(1, 2'b10, 12'h341, 32'h0000_00F0, 1'b0);
        waitAccept(1);
        waitIdle();
        checkOutput("rsCsrValue", {32'd0, envMem[1]}, 64'h0FF);
        checkOutput("rsRspData", {32'd0, lastRspData}, 64'h00F);
        applyStimulus(0, 2'b11, 12'h341, 32'h0000_000F, 1'b0);
        waitAccept(0);
        waitIdle();
        checkOutput("rcCsrValue", {32'd0, envMem[1]}, 64'h0F0);
        checkOutput("rcRspData", {32'd0, lastRspData}, 64'h0FF);

        // Set with a zero operand register and reserved op: both read-only.
        wcBefore = writeCount;
        applyStimulus(0, 2'b10, 12'h342, 32'h0000_0F00, 1'b1);
        waitAccept(0);
        waitIdle();
        checkOutput("skipRspData", {32'd0, lastRspData}, 64'h55);
        checkOutput("skipCsrValue", {32'd0, envMem[2]}, 64'h55);
        applyStimulus(1, 2'b00, 12'h343, 32'hFFFF_FFFF, 1'b0);
        waitAccept(1);
        waitIdle();
        checkOutput("op00RspData", {32'd0, lastRspData}, 64'hA5A5);
        checkOutput("noWriteCount", 64'(writeCount), 64'(wcBefore));

        // Response back-pressure with a competing request pending.
        rsp_ready = 1'b0;
        applyStimulus(0, 2'b01, 12'h341, 32'h0000_0077, 1'b0);
        applyStimulus(1, 2'b00, 12'h343, 32'h0, 1'b0);
        waitAccept(0);
        for (int n = 0; n < 10 && !rsp_valid; n++) @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checkOutput("holdRspData", {32'd0, rsp_data}, 64'h0F0);
            checkOutput("holdNoGrant", {62'd0, req_ready}, 64'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        waitAccept(1);
        waitIdle();

        // Continuous contention from reset alternates 0,1,0,1.
        doReset();
        grantLog.delete();
        applyStimulus(0, 2'b00, 12'h340, 32'h0, 1'b0);
        applyStimulus(1, 2'b00, 12'h341, 32'h0, 1'b0);
        for (int n = 0; n < 60 && grantLog.size() < 4; n++) @(posedge clk);
        #1 req_valid = '0;
        waitIdle();
        checkOutput("altCount", 64'(grantLog.size()), 64'd4);
        for (int i = 0; i < 4 && i < grantLog.size(); i++) begin
            checkOutput("altOrder", 64'(grantLog[i]), 64'(i % 2));
        end

        // Reset while in WRITE aborts the transaction and rewinds the pointer.
        wcBefore = writeCount;
        rcBefore = rspCount;
        applyStimulus(0, 2'b01, 12'h340, 32'h0000_BEEF, 1'b0);
        waitAccept(0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        grantLog.delete();
        applyStimulus(0, 2'b00, 12'h342, 32'h0, 1'b0);
        applyStimulus(1, 2'b00, 12'h343, 32'h0, 1'b0);
        for (int n = 0; n < 20 && grantLog.size() < 1; n++) @(posedge clk);
        #1 req_valid = '0;
        waitIdle();
        checkOutput("abortNoWrite", 64'(writeCount), 64'(wcBefore));
        checkOutput("abortNoRsp", 64'(rspCount), 64'(rcBefore + 1));
        checkOutput("abortFirstGrant", 64'(grantLog.size() > 0 ? grantLog[0] : -1), 64'd0);

        // Randomised traffic with dropped requests and response stalls.
        for (int cIdx = 0; cIdx < 800; cIdx++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int r = 0; r < NR; r++) begin
                if (acc[r] || $urandom_range(0, 3) == 0) begin
                    u = {$urandom, $urandom};
                    req_op[r*2 +: 2]     = 2'($urandom_range(0, 3));
                    req_addr[r*12 +: 12] = 12'h340 + 12'($urandom_range(0, 3));
                    req_wid[r*2 +: 2]    = 2'($urandom_range(0, 3));
                    req_uuid[r*44 +: 44] = u[43:0];
                    req_data[r*32 +: 32] = $urandom;
                    req_wr_skip[r]       = ($urandom_range(0, 2) == 0);
                end
                req_valid[r] = ($urandom_range(0, 9) < 6);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        waitIdle();
        checkOutput("drainRead", 64'(rdQ.size()), 64'd0);
        checkOutput("drainWrite", 64'(wrQ.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/vx_csr_access_arb.md
VX_CSR_ACCESS_ARB -- requirements
Module: VX_csr_access_arb

Interface
REQ-001 Parameter NUM_REQS, default 2: number of requesters sharing the CSR data port.
REQ-002 Parameter DATA_WIDTH, default 32: CSR data width (XLEN).
REQ-003 Parameter ADDR_BITS, default 12: CSR address width.
REQ-004 Parameter NW_WIDTH, default 2: warp-id width.
REQ-005 Parameter UUID_WIDTH, default 44: instruction uuid width.
REQ-006 Port clk, input, 1: clock, rising edge.
REQ-007 Port reset, input, 1: synchronous, active-high.
REQ-008 Port req_valid, input, NUM_REQS: per-requester request valid.
REQ-009 Port req_ready, output, NUM_REQS: per-requester accept.
REQ-010 Port req_op, input, NUM_REQS x 2: 01 CSRRW, 10 CSRRS, 11 CSRRC; 00 reserved.
REQ-011 Port req_addr / req_wid / req_uuid, input, NUM_REQS x ADDR_BITS / NW_WIDTH / UUID_WIDTH: target CSR, warp, uuid.
REQ-012 Port req_data, input, NUM_REQS x DATA_WIDTH: rs1/immediate operand.
REQ-013 Port req_wr_skip, input, NUM_REQS: operand register is x0/zero-immediate (suppresses write for RS/RC).
REQ-014 Ports csr_read_enable, csr_read_addr, csr_read_wid, csr_read_uuid, output, 1/ADDR_BITS/NW_WIDTH/UUID_WIDTH: CSR read port drive.
REQ-015 Ports csr_read_data_ro, csr_read_data_rw, input, DATA_WIDTH each: combinational read data.
REQ-016 Ports csr_write_enable, csr_write_addr, csr_write_wid, csr_write_uuid, csr_write_data, output: CSR write port drive.
REQ-017 Ports rsp_valid output 1, rsp_ready input 1, rsp_idx output clog2(NUM_REQS) (min 1), rsp_data output DATA_WIDTH: old CSR value returned to winner.

Function
REQ-018 FSM states IDLE, READ, WRITE, RESP; one transaction in flight.
REQ-019 IDLE: round-robin grant among req_valid; req_ready asserted only for winner, only in IDLE; handshake at cycle T latches op/addr/wid/uuid/data/skip/index, next state READ.
REQ-020 Round-robin pointer resets to 0; after grant it becomes (winner+1) mod NUM_REQS; search starts at pointer.
REQ-021 READ (T+1): csr_read_enable=1 for exactly one cycle with latched addr/wid/uuid; capture old = csr_read_data_ro | csr_read_data_rw; next WRITE.
REQ-022 WRITE (T+2): new = data (RW), old|data (RS), old & ~data (RC); csr_write_enable=1 one cycle unless (op RS/RC and skip); RW always writes; next RESP.
REQ-023 RESP (T+3 onward): rsp_valid=1, rsp_data=old, rsp_idx=winner; held stable until rsp_valid&&rsp_ready, then IDLE; earliest next grant cycle after handshake.
REQ-024 Throughput: minimum 4 cycles per transaction with rsp_ready tied high.
REQ-025 Op 00 accepted and treated as read-only: no write, response returned.
REQ-026 csr_*_enable and rsp_valid are 0 outside their states; address/data outputs are don't-care while enable low.
REQ-027 Requester dropping req_valid without handshake has no effect; no request is lost once accepted.

Reset
REQ-028 Reset forces IDLE, pointer 0, req_ready=0, rsp_valid=0, csr_read_enable=0, csr_write_enable=0, latched fields 0.
REQ-029 Reset mid-transaction aborts it: no write issued, no response, following cycle IDLE.

Structure
REQ-030 Op encodings and FSM state enum belong in VX_gpu_pkg; widths come from VX_define.vh macros.
REQ-031 Round-robin selection is the sub-module VX_rr_arbiter (NUM_REQS, grant one-hot plus index, pointer update on enable).

Verification
REQ-032 Single CSRRW req0 addr 0x340 data 0xDEAD, old 0x1234 -> read T+1, write 0xDEAD T+2, rsp_data 0x1234 idx 0 T+3.
REQ-033 CSRRS data 0x0F0, old 0x00F -> write 0x0FF; CSRRC data 0x00F, old 0x0FF -> write 0x0F0.
REQ-034 CSRRS with req_wr_skip=1 -> no csr_write_enable, rsp_data = old.
REQ-035 Both requesters valid continuously -> grants alternate 0,1,0,1 from reset.
REQ-036 rsp_ready low 5 cycles -> rsp_valid/rsp_data stable, no new grant until handshake.
REQ-037 reset asserted in WRITE state -> no write pulse, no response, IDLE next cycle, pointer 0.
